wb_uart_rx: RTL

- Wishbone classic slave UART receiver (8N1, 16x oversampling) with a receive FIFO.
- Counterpart of the SoC's UART transmit path. Lets the SoC, or a second board, accept serial bytes from an external host on a GPIO pin.
- Sits on the wb_clk domain; the CPU reads data/status registers over Wishbone; irq_o flags pending data.

---
 rtl/wb_uart_pkg.sv | 26 ++
 rtl/wb_uart_rx_if.sv | 23 ++
 rtl/wb_uart_rx_sync_fifo.sv | 61 ++++++
 rtl/wb_uart_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// Shared constants for the Wishbone UART receive path: register offsets,
// STATUS bit positions, receiver FSM states and oversampling constants.
package wb_uart_pkg;

  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone classic bus bundle for the UART receiver register slave.
interface wb_uart_rx_if;

  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_uart_rx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop on a full FIFO frees the slot
// for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone classic UART receiver: 8N1 framing with 16x oversampling, a receive
// FIFO, sticky overrun/framing flags and a level interrupt while data waits.
module wb_uart_rx
  import wb_uart_pkg::*;
#(
  parameter int unsigned DIVISOR_RESET = 12,
  parameter int          FIFO_AW       = 4
) (
  input  logic         clock,
  input  logic         reset,
  wb_uart_rx_if.slave  wb,
  input  logic         uart_rx,
  output logic         irq_o
);

  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] divisor_q, divisor_d;
  logic        baud_tick;

  rx_state_e   state_q, state_d;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_push, frame_err_set;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [FIFO_AW:0] fifo_count;

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rd_data;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        wb_req, rd_en, wr_en, div_wr, clr_ovr, clr_ferr;
  logic [1:0]  reg_sel;

  logic        unused_bits;
  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], fifo_count};

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = ~fifo_empty;

  // Bus decode: one request per access, accepted only while ack is low.
  always_comb begin
    reg_sel  = wb.wb_adr_i[3:2];
    wb_req   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    rd_en    = wb_req & ~wb.wb_we_i;
    wr_en    = wb_req & wb.wb_we_i;
    fifo_pop = rd_en & (reg_sel == REG_RXDATA) & ~fifo_empty;
    div_wr   = wr_en & (reg_sel == REG_DIVISOR);
    clr_ovr  = wr_en & (reg_sel == REG_STATUS) & wb.wb_dat_i[ST_OVERRUN];
    clr_ferr = wr_en & (reg_sel == REG_STATUS) & wb.wb_dat_i[ST_FRAME_ERR];

    rd_data = '0;
    unique case (reg_sel)
      REG_RXDATA:  rd_data[7:0] = fifo_empty ? 8'd0 : fifo_dout;
      REG_STATUS: begin
        rd_data[ST_NOT_EMPTY] = ~fifo_empty;
        rd_data[ST_FULL]      = fifo_full;
        rd_data[ST_OVERRUN]   = overrun_q;
        rd_data[ST_FRAME_ERR] = frame_err_q;
      end
      REG_DIVISOR: rd_data[15:0] = divisor_q;
      default:     rd_data = '0;
    endcase

    ack_d     = wb_req;
    dat_d     = rd_en ? rd_data : dat_q;
    divisor_d = div_wr ? wb.wb_dat_i[15:0] : divisor_q;
    // Set wins over a simultaneous clear so a fresh event is never lost.
    overrun_d   = (overrun_q & ~clr_ovr) | (rx_push & fifo_full & ~fifo_pop);
    frame_err_d = (frame_err_q & ~clr_ferr) | frame_err_set;
  end

  always_comb begin
    sync1_d    = uart_rx;
    sync2_d    = sync1_q;
    baud_tick  = (baud_cnt_q == divisor_q);
    baud_cnt_d = (div_wr | baud_tick) ? 16'd0 : baud_cnt_q + 16'd1;
  end

  // Receiver FSM; every decision uses the second synchronizer stage.
  always_comb begin
    state_d       = state_q;
    samp_d        = samp_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        samp_d = 4'd0;
        bit_d  = 3'd0;
        if (!sync2_q) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          if (samp_q == MID_SAMPLE) begin
            samp_d  = 4'd0;
            state_d = sync2_q ? S_IDLE : S_DATA;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == LAST_SAMPLE) begin
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          samp_d = samp_q + 4'd1;
          if (samp_q == LAST_SAMPLE) begin
            rx_push       = sync2_q;
            frame_err_set = ~sync2_q;
            state_d       = sync2_q ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (div_wr) state_d = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      baud_cnt_q  <= 16'd0;
      divisor_q   <= 16'(DIVISOR_RESET);
      state_q     <= S_IDLE;
      samp_q      <= 4'd0;
      bit_q       <= 3'd0;
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      baud_cnt_q  <= baud_cnt_d;
      divisor_q   <= divisor_d;
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_q       <= bit_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
    shift_q <= shift_d;
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .din   (shift_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
